// File: rtl/br_flow_mux_reg_tagged.sv
// Registered, flow-tagged output stage for the round-robin flow arbiter.
// Captures the granted flow's payload and its binary flow index into a
// two-entry (main + skid) buffer. The consumer sees a fully registered
// ready/valid interface, and push_ready has no combinational path from
// pop_ready or push_valid.
module br_flow_mux_reg_tagged #(
  parameter int NumFlows = 2,
  parameter int Width = 1,
  parameter int EnableAssertFinalNotValid = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic                                 push_ready,
  input  logic                                 push_valid,
  input  logic [NumFlows-1:0]                  push_grant,
  input  logic [NumFlows*Width-1:0]            push_data,
  input  logic                                 pop_ready,
  output logic                                 pop_valid,
  output logic [Width-1:0]                     pop_data,
  output logic [((NumFlows > 1) ? $clog2(NumFlows) : 1)-1:0] pop_flow_id
);

  localparam int IdWidth = (NumFlows > 1) ? $clog2(NumFlows) : 1;

  logic               main_valid_reg, main_valid_next;
  logic [Width-1:0]   main_data_reg, main_data_next;
  logic [IdWidth-1:0] main_id_reg, main_id_next;
  logic               skid_valid_reg, skid_valid_next;
  logic [Width-1:0]   skid_data_reg, skid_data_next;
  logic [IdWidth-1:0] skid_id_reg, skid_id_next;

  logic               push_acc;
  logic               pop_acc;
  logic [Width-1:0]   masked_data [NumFlows];
  logic [Width-1:0]   in_data;
  logic [IdWidth-1:0] in_id;

  // The grant is one-hot, so gating each flow's payload by its grant bit
  // and OR-ing the results selects the granted payload.
  genvar gi;
  generate
    for (gi = 0; gi < NumFlows; gi++) begin : g_mask
      assign masked_data[gi] = push_data[gi*Width +: Width] & {Width{push_grant[gi]}};
    end
  endgenerate

  // Select the granted payload and binary-encode the one-hot grant.
  always_comb begin
    in_data = '0;
    in_id   = '0;
    for (int i = 0; i < NumFlows; i++) begin
      in_data = in_data | masked_data[i];
      if (push_grant[i]) in_id = in_id | IdWidth'(i);
    end
  end

  assign push_acc = push_valid & push_ready;
  assign pop_acc  = main_valid_reg & pop_ready;

  // Next-state for the two entries: main refills from skid first (FIFO
  // order), otherwise from the input; skid only fills when main is busy.
  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    main_id_next    = main_id_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_id_next    = skid_id_reg;
    if (pop_acc || !main_valid_reg) begin
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        main_id_next    = skid_id_reg;
        skid_valid_next = 1'b0;
      end else if (push_acc) begin
        main_valid_next = 1'b1;
        main_data_next  = in_data;
        main_id_next    = in_id;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (push_acc) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
      skid_id_next    = in_id;
    end
  end

  // Entry registers, cleared asynchronously so outputs are idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      main_id_reg    <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_id_reg    <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      main_id_reg    <= main_id_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_id_reg    <= skid_id_next;
    end
  end

  assign push_ready  = ~skid_valid_reg;
  assign pop_valid   = main_valid_reg;
  assign pop_data    = main_data_reg;
  assign pop_flow_id = main_id_reg;

`ifndef SYNTHESIS
  logic               hold_chk_reg;
  logic [Width-1:0]   hold_data_reg;
  logic [IdWidth-1:0] hold_id_reg;

  // Integration and implementation checks; the hold tracker is cleared by
  // reset so a reset during backpressure is not flagged as instability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_chk_reg  <= 1'b0;
      hold_data_reg <= '0;
      hold_id_reg   <= '0;
    end else begin
      if (push_valid) assert ($onehot(push_grant))
        else $error("push_grant not one-hot while push_valid");
      assert (!(skid_valid_reg && !main_valid_reg))
        else $error("skid valid while main empty");
      if (hold_chk_reg) assert (main_valid_reg && main_data_reg == hold_data_reg &&
                                main_id_reg == hold_id_reg)
        else $error("pop side changed while stalled");
      hold_chk_reg  <= main_valid_reg & ~pop_ready;
      hold_data_reg <= main_data_reg;
      hold_id_reg   <= main_id_reg;
    end
  end

  final begin
    if (EnableAssertFinalNotValid != 0) assert (!pop_valid)
      else $error("pop_valid still set at end of test");
  end
`endif

endmodule

// File: tb/tb_br_flow_mux_reg_tagged.sv
// Bench for br_flow_mux_reg_tagged: directed scenarios followed by random
// traffic, all checked against a queue-based reference of the stage.
module tb_br_flow_mux_reg_tagged;
  localparam int NF = 4;
  localparam int W  = 8;

  logic          clk;
  logic          rst_n;
  logic          push_ready;
  logic          push_valid;
  logic [NF-1:0] push_grant;
  logic [NF*W-1:0] push_data;
  logic          pop_ready;
  logic          pop_valid;
  logic [W-1:0]  pop_data;
  logic [1:0]    pop_flow_id;

  br_flow_mux_reg_tagged #(.NumFlows(NF), .Width(W), .EnableAssertFinalNotValid(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_ready(push_ready), .push_valid(push_valid),
    .push_grant(push_grant), .push_data(push_data),
    .pop_ready(pop_ready), .pop_valid(pop_valid),
    .pop_data(pop_data), .pop_flow_id(pop_flow_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   id;
  } item_t;

  item_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs predicted from the queue: anything held is visible at the head,
  // and the stage can take more while it holds fewer than two items.
  task automatic check_model();
    chk("pop_valid", {31'd0, pop_valid}, {31'd0, q.size() > 0});
    chk("push_ready", {31'd0, push_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      chk("pop_data", {24'd0, pop_data}, {24'd0, q[0].d});
      chk("pop_flow_id", {30'd0, pop_flow_id}, {30'd0, q[0].id});
    end
  endtask

  // One clock: decide handshakes from the model, advance, update, check.
  task automatic cycle();
    bit    do_push, do_pop;
    item_t it;
    do_push = push_valid && (q.size() < 2);
    do_pop  = (q.size() > 0) && pop_ready;
    it.d  = '0;
    it.id = '0;
    for (int i = 0; i < NF; i++) begin
      if (push_grant[i]) begin
        it.d  = push_data[i*W +: W];
        it.id = 2'(i);
      end
    end
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(it);
    check_model();
  endtask

  task automatic drive(input bit v, input int flow, input logic [W-1:0] d);
    push_valid = v;
    push_grant = NF'(1) << flow;
    push_data  = {$urandom, $urandom} >> 32;
    push_data[flow*W +: W] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    push_valid = 1'b0;
    push_grant = '0;
    push_data = '0;
    pop_ready = 1'b0;
    #3;
    chk("reset_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("reset_push_ready", {31'd0, push_ready}, 32'd1);
    chk("reset_pop_data", {24'd0, pop_data}, 32'd0);
    chk("reset_pop_flow_id", {30'd0, pop_flow_id}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single item from flow 2.
    drive(1'b1, 2, 8'hA5);
    pop_ready = 1'b1;
    cycle();
    chk("single_data", {24'd0, pop_data}, 32'hA5);
    chk("single_id", {30'd0, pop_flow_id}, 32'd2);
    push_valid = 1'b0;
    cycle();
    chk("single_gone", {31'd0, pop_valid}, 32'd0);

    // Streaming: 16 back-to-back grants cycling flows 0..3.
    for (int s = 0; s < 16; s++) begin
      drive(1'b1, s % 4, W'(s));
      cycle();
      chk("stream_data", {24'd0, pop_data}, 32'(s));
      chk("stream_id", {30'd0, pop_flow_id}, 32'(s % 4));
      chk("stream_ready", {31'd0, push_ready}, 32'd1);
    end
    push_valid = 1'b0;
    cycle();

    // Backpressure: two pushes fill the stage, a third is not sampled.
    pop_ready = 1'b0;
    drive(1'b1, 1, 8'h11);
    cycle();
    drive(1'b1, 3, 8'h22);
    cycle();
    chk("bp_ready_low", {31'd0, push_ready}, 32'd0);
    drive(1'b1, 0, 8'h33);
    cycle();
    chk("bp_hold_data", {24'd0, pop_data}, 32'h11);
    push_valid = 1'b0;
    pop_ready = 1'b1;
    cycle();
    chk("bp_second_data", {24'd0, pop_data}, 32'h22);
    chk("bp_second_id", {30'd0, pop_flow_id}, 32'd3);
    chk("bp_ready_back", {31'd0, push_ready}, 32'd1);
    cycle();
    chk("bp_drained", {31'd0, pop_valid}, 32'd0);

    // Fill again, then wiggle the upstream valid and grant while full.
    pop_ready = 1'b0;
    drive(1'b1, 0, 8'h44);
    cycle();
    drive(1'b1, 2, 8'h55);
    cycle();
    for (int k = 0; k < 8; k++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, NF - 1)), W'($urandom));
      cycle();
      chk("unstable_data", {24'd0, pop_data}, 32'h44);
    end

    // Asynchronous reset while full.
    push_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_pop_valid", {31'd0, pop_valid}, 32'd0);
    chk("midrst_push_ready", {31'd0, push_ready}, 32'd1);
    chk("midrst_pop_data", {24'd0, pop_data}, 32'd0);
    #1;
    rst_n = 1'b1;
    pop_ready = 1'b1;
    drive(1'b1, 1, 8'h5A);
    cycle();
    chk("post_rst_data", {24'd0, pop_data}, 32'h5A);
    chk("post_rst_id", {30'd0, pop_flow_id}, 32'd1);
    push_valid = 1'b0;
    cycle();

    // Random traffic against the queue reference.
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, NF - 1)), W'($urandom));
      pop_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    push_valid = 1'b0;
    pop_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    chk("final_not_valid", {31'd0, pop_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/br_flow_mux_reg_tagged.md
# br_flow_mux_reg_tagged

Registered, flow-tagged data stage that sits directly downstream of the round-robin flow arbiter. It consumes the arbiter's pop handshake, its one-hot grant and the per-flow payloads. It captures the granted payload together with its binary flow index into a 2-entry full-throughput buffer and presents a stable, registered ready-valid interface to the consumer. It breaks the combinational ready/valid path and masks the arbiter's `pop_valid_unstable` behaviour from everything downstream.

## Interface
- `NumFlows`, default 2: number of arbitrated flows; must be ≥ 2.
- `Width`, default 1: payload width per flow; must be ≥ 1.
- `EnableAssertFinalNotValid`, default 1: if 1, assert that `pop_valid` is 0 at end of test.
- `clk`, input, 1: sole clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `push_ready`, output, 1: stage can accept; drives the arbiter's `pop_ready`.
- `push_valid`, input, 1: from the arbiter's `pop_valid_unstable`; may drop without a handshake.
- `push_grant`, input, NumFlows: one-hot grant from the arbiter; qualified by `push_valid`.
- `push_data`, input, NumFlows×Width: flow *i* payload at bits [i×Width +: Width].
- `pop_ready`, input, 1: consumer ready.
- `pop_valid`, output, 1: registered valid.
- `pop_data`, output, Width: registered payload of the granted flow.
- `pop_flow_id`, output, max(1, $clog2(NumFlows)): binary index of the flow that produced `pop_data`.

## Operation
- Storage is two entries, **main** and **skid**. Each entry holds a valid bit, a Width payload and a flow id.
  - `pop_*` is driven directly from main.
  - `push_ready` = !skid.valid, taken from a flop with no combinational path from `pop_ready` or `push_valid`.
- Push accept: `push_valid & push_ready`. On accept the stage captures `push_data` for the granted flow and the binary encode of `push_grant`. Nothing is sampled without a push accept.
- Pop accept: `pop_valid & pop_ready`.
- Effective states (main.valid, skid.valid):
  - **EMPTY (0,0)**:
    - push accept → ONE, with main loaded.
  - **ONE (1,0)**:
    - pop accept with no push → EMPTY.
    - push and pop together → ONE, with main reloaded.
    - push without pop → FULL, with skid loaded.
  - **FULL (1,1)**, `push_ready` = 0:
    - pop accept → ONE, with skid moved into main.
  - (0,1) is unreachable; assert it never occurs.
- Order is strictly FIFO. No entry is dropped or duplicated.
- Integration assertions:
  - `push_grant` is one-hot whenever `push_valid` = 1.
  - `pop_valid` and `pop_data`/`pop_flow_id` are stable while `pop_valid & !pop_ready`. This holds by construction; check it with an implementation assertion.
- Do not assert push-side valid stability. The upstream arbiter may legally withdraw `push_valid` while `push_ready` = 0.
- Arithmetic: `pop_flow_id` is the index of the single set bit of `push_grant`. For NumFlows = 2 the width is 1.

## Timing
- Reset (`rst_n` low, asynchronous assertion): main.valid = skid.valid = 0 and payload/id registers = 0. Therefore `pop_valid` = 0, `pop_data` = 0, `pop_flow_id` = 0 and `push_ready` = 1 immediately, without waiting for a clock edge.
- Reset deassertion is synchronised by the integrator. The first push accept can occur on the first rising edge after `rst_n` rises.
- Latency: a push accepted at edge N is visible on `pop_*` after edge N. With an empty stage, `pop_valid` = 1 in cycle N+1.
- Throughput: 1 item per cycle sustained with `pop_ready` held high. FULL is only reached under consumer backpressure.
- `push_ready` falls one cycle after the push that fills skid. It rises one cycle after the pop that drains skid. This is the 1-cycle bubble-free skid behaviour.
- Reset mid-operation clears both entries asynchronously. In-flight data is discarded, not flushed.

## Test plan
- Single item: NumFlows = 4, Width = 8; `push_grant` = 4'b0100, flow-2 data 8'hA5 for one cycle, `pop_ready` = 1 → next cycle `pop_valid` = 1, `pop_data` = 8'hA5, `pop_flow_id` = 2. The cycle after, `pop_valid` = 0.
- Streaming: 16 back-to-back grants cycling flows 0→3 with data = sequence number, `pop_ready` = 1 → 16 pops on consecutive cycles, in order, with `pop_flow_id` = seq mod 4 and `push_ready` always 1.
- Backpressure: `pop_ready` = 0 and two pushes (data 8'h11 from flow 1, then 8'h22 from flow 3):
  - `push_ready` = 0 from the following cycle.
  - A third `push_valid` is not sampled.
  - Raise `pop_ready` → pops 8'h11/id 1, then 8'h22/id 3; `push_ready` returns to 1 after the first pop.
- Unstable upstream valid: while FULL, toggle `push_valid` and `push_grant` randomly → stored contents and `pop_*` are unchanged, and no assertion fires.
- Reset mid-operation: with the stage FULL, pulse `rst_n` low between clock edges → `pop_valid` = 0 and `push_ready` = 1 asynchronously. After release, a new push is delivered with no stale data.
- Random: constrained-random `push_valid`, grant and `pop_ready` over 10k cycles against a scoreboard FIFO → exact data/id order match and `pop_valid` = 0 at end.
